fixed_alu: RTL and testbench

FIXED_ALU -- requirements
Module: fixed_alu

---
 rtl/fixed_pkg.sv | 52 +++++
 rtl/fixed_div.sv | 110 +++++++++++
 rtl/fixed_alu.sv | 162 ++++++++++++++++
 tb/tb_fixed_alu.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared types and helpers for the signed fixed-point ALU.
package fixed_pkg;

    // Widest word the saturation helper supports; intermediates are twice this.
    localparam int MAXW = 64;

    typedef logic signed [2*MAXW-1:0] wide_t;

    localparam wide_t WIDE_ONE = {{(2*MAXW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL2    = 3'd1,
        DIV_RUN = 3'd2,
        DIV_FIX = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic            ovf;
        logic [MAXW-1:0] value;
    } sat_t;

    // Clamp a wide signed value into a signed word of 'width' bits.
    // The clamped word is returned in the low 'width' bits of value.
    function automatic sat_t saturate(input wide_t v, input int width);
        wide_t max_w;
        wide_t min_w;
        sat_t  r;
        max_w = (WIDE_ONE <<< (width - 1)) - WIDE_ONE;
        min_w = ~max_w;
        if (v > max_w) begin
            r.ovf   = 1'b1;
            r.value = MAXW'(max_w);
        end else if (v < min_w) begin
            r.ovf   = 1'b1;
            r.value = MAXW'(min_w);
        end else begin
            r.ovf   = 1'b0;
            r.value = MAXW'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/fixed_div.sv
// Iterative restoring divider for signed Q values: (A << F) / B on
// magnitudes, one quotient bit per cycle, sign and saturation applied
// on the final quotient. Divide-by-zero still runs the full iteration count.
module fixed_div
    import fixed_pkg::*;
#(
    parameter int N = 32,
    parameter int F = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start_i,
    input  logic [N-1:0] dividend_i,
    input  logic [N-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic         ovf_o,
    output logic         dz_o
);

    localparam int QW = N + F;
    localparam int CW = $clog2(QW + 1);
    localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  MAX_N    = {1'b0, {(N-1){1'b1}}};
    localparam logic [CW-1:0] LAST_CNT = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ITER_CNT = CW'(QW);

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [QW-1:0] dvd_q;     // dividend shifts out the top, quotient shifts in
    logic [N-1:0]  rem_q;
    logic [N-1:0]  dsr_q;
    logic          neg_q;
    logic          a_neg_q;
    logic          dz_q;

    logic [N-1:0]  a_mag_s;
    logic [N-1:0]  b_mag_s;
    logic [N:0]    rem_sh_s;
    logic          fits_s;
    logic [N-1:0]  rem_nx_s;
    wide_t         quo_w_s;
    sat_t          sat_s;
    logic [N-1:0]  result_s;
    logic          ovf_s;

    // Operand magnitudes, one restoring step, and the signed saturated quotient.
    always_comb begin
        a_mag_s  = dividend_i[N-1] ? (~dividend_i + ONE_N) : dividend_i;
        b_mag_s  = divisor_i[N-1]  ? (~divisor_i + ONE_N)  : divisor_i;
        rem_sh_s = {rem_q, dvd_q[QW-1]};
        fits_s   = (rem_sh_s >= {1'b0, dsr_q});
        if (fits_s) begin
            rem_nx_s = N'(rem_sh_s - {1'b0, dsr_q});
        end else begin
            rem_nx_s = N'(rem_sh_s);
        end
        quo_w_s = '0;
        quo_w_s[QW-1:0] = dvd_q;
        if (neg_q) begin
            quo_w_s = -quo_w_s;
        end else begin
            quo_w_s = quo_w_s;
        end
        sat_s = saturate(quo_w_s, N);
        if (dz_q) begin
            result_s = a_neg_q ? ~MAX_N : MAX_N;
            ovf_s    = 1'b1;
        end else begin
            result_s = N'(sat_s.value);
            ovf_s    = sat_s.ovf;
        end
    end

    // Load operands on start, then iterate one quotient bit per cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else if (start_i) begin
            busy_q  <= 1'b1;
            cnt_q   <= ITER_CNT;
            dvd_q   <= {a_mag_s, {F{1'b0}}};
            rem_q   <= '0;
            dsr_q   <= b_mag_s;
            neg_q   <= dividend_i[N-1] ^ divisor_i[N-1];
            a_neg_q <= dividend_i[N-1];
            dz_q    <= (divisor_i == '0);
        end else if (busy_q) begin
            rem_q  <= rem_nx_s;
            dvd_q  <= {dvd_q[QW-2:0], fits_s};
            cnt_q  <= cnt_q - LAST_CNT;
            busy_q <= (cnt_q != LAST_CNT);
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = busy_q && (cnt_q == LAST_CNT);
    assign result_o = result_s;
    assign ovf_o    = ovf_s;
    assign dz_o     = dz_q;

endmodule

// File: rtl/fixed_alu.sv
// Saturating signed Q-format ALU: ADD/SUB in one cycle, rounded MUL in two,
// iterative DIV via fixed_div. One operation in flight, valid/ready handshakes.
module fixed_alu
    import fixed_pkg::*;
#(
    parameter int wholeWidth    = 16,
    parameter int fractionWidth = 16
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [1:0]                          op,
    input  logic [wholeWidth+fractionWidth-1:0] valueOne,
    input  logic [wholeWidth+fractionWidth-1:0] valueTwo,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [wholeWidth+fractionWidth-1:0] result,
    output logic                                overflow,
    output logic                                div_zero
);

    localparam int N = wholeWidth + fractionWidth;
    localparam int F = fractionWidth;

    state_t               state_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [N-1:0]         result_q;
    logic                 overflow_q;
    logic                 div_zero_q;
    logic signed [N-1:0]  a_q;
    logic signed [N-1:0]  b_q;

    logic                 accept_s;
    logic                 div_start_s;
    logic signed [N:0]    sum_s;
    sat_t                 add_sat_s;
    logic signed [2*N-1:0] prod_s;
    wide_t                rnd_s;
    sat_t                 mul_sat_s;
    logic                 div_busy_s;
    logic                 div_done_s;
    logic [N-1:0]         div_result_s;
    logic                 div_ovf_s;
    logic                 div_dz_s;

    assign accept_s    = in_valid && in_ready_q;
    assign div_start_s = accept_s && (op_t'(op) == DIV);

    // Guard-bit add/sub on the live inputs and rounded product of captured operands.
    always_comb begin
        if (op_t'(op) == SUB) begin
            sum_s = {valueOne[N-1], valueOne} - {valueTwo[N-1], valueTwo};
        end else begin
            sum_s = {valueOne[N-1], valueOne} + {valueTwo[N-1], valueTwo};
        end
        add_sat_s = saturate(wide_t'(sum_s), N);
        prod_s    = {{N{a_q[N-1]}}, a_q} * {{N{b_q[N-1]}}, b_q};
        rnd_s     = wide_t'(prod_s) + (WIDE_ONE <<< (F - 1));
        mul_sat_s = saturate(rnd_s >>> F, N);
    end

    fixed_div #(
        .N (N),
        .F (F)
    ) u_div (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_i    (div_start_s),
        .dividend_i (valueOne),
        .divisor_i  (valueTwo),
        .busy_o     (div_busy_s),
        .done_o     (div_done_s),
        .result_o   (div_result_s),
        .ovf_o      (div_ovf_s),
        .dz_o       (div_dz_s)
    );

    // Operation sequencer with registered handshake and result outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            div_zero_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        a_q        <= valueOne;
                        b_q        <= valueTwo;
                        in_ready_q <= 1'b0;
                        case (op_t'(op))
                            ADD, SUB: begin
                                result_q    <= N'(add_sat_s.value);
                                overflow_q  <= add_sat_s.ovf;
                                div_zero_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
                            MUL:     state_q <= MUL2;
                            DIV:     state_q <= DIV_RUN;
                            default: begin
                                state_q    <= IDLE;
                                in_ready_q <= 1'b1;
                            end
                        endcase
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                MUL2: begin
                    result_q    <= N'(mul_sat_s.value);
                    overflow_q  <= mul_sat_s.ovf;
                    div_zero_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DIV_RUN: begin
                    if (div_done_s) begin
                        state_q <= DIV_FIX;
                    end else if (!div_busy_s) begin
                        // Divider lost its operation: drop it rather than hang.
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                DIV_FIX: begin
                    result_q    <= div_result_s;
                    overflow_q  <= div_ovf_s;
                    div_zero_q  <= div_dz_s;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_fixed_alu.sv
// Self-checking bench for fixed_alu at the default Q16.16 format.
module tb_fixed_alu;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] valueOne;
    logic [31:0] valueTwo;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        div_zero;

    fixed_alu #(.wholeWidth(16), .fractionWidth(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .valueOne  (valueOne),
        .valueTwo  (valueTwo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        dz;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model using 64-bit integer arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sbv, r, ma, mb, q;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        e.dz = 1'b0;
        e.ovf = 1'b0;
        case (o)
            2'd0: begin r = sa + sbv; e.lat = 1; end
            2'd1: begin r = sa - sbv; e.lat = 1; end
            2'd2: begin r = (sa * sbv + 64'sd32768) >>> 16; e.lat = 2; end
            default: begin
                e.lat = 50;
                if (b == 32'd0) begin
                    e.dz = 1'b1;
                    r = (sa < 0) ? -64'sd4294967296 : 64'sd4294967296;
                end else begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sbv < 0) ? -sbv : sbv;
                    q  = (ma * 64'sd65536) / mb;
                    r  = ((sa < 0) != (sbv < 0)) ? -q : q;
                end
            end
        endcase
        if (r > 64'sd2147483647) begin
            r = 64'sd2147483647; e.ovf = 1'b1;
        end else if (r < -64'sd2147483648) begin
            r = -64'sd2147483648; e.ovf = 1'b1;
        end
        e.res = r[31:0];
        return e;
    endfunction

    // Wait (bounded) for in_ready, present one operation, return after its accept edge.
    task automatic send_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 100) begin
            @(posedge clock); #1; w++;
        end
        checks++;
        if (in_ready !== 1'b1) $display("FAIL in_ready_wait: got %b want 1", in_ready);
        else passed++;
        in_valid = 1'b1; op = o; valueOne = a; valueTwo = b;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid (bounded).
    task automatic wait_out(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clock); #1; lat++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'd0; valueOne = 32'd0; valueTwo = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (result !== 32'd0) $display("FAIL rst_result: got %h want 0", result); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else passed++;
        checks++; if (div_zero !== 1'b0) $display("FAIL rst_div_zero: got %b want 0", div_zero); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else passed++;
        reset_n = 1'b1;
        @(posedge clock); #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_arith();
        vec_t vecs[12] = '{
            '{2'd0, 32'h00010001, 32'h00010151},
            '{2'd0, 32'h7FFF0000, 32'h00010000},
            '{2'd1, 32'h80000000, 32'h00000001},
            '{2'd1, 32'h00050000, 32'h00078000},
            '{2'd2, 32'h00020000, 32'h00018000},
            '{2'd2, 32'h00000001, 32'h00008000},
            '{2'd2, 32'h80000000, 32'h80000000},
            '{2'd3, 32'h00030000, 32'h00020000},
            '{2'd3, 32'hFFFD0000, 32'h00020000},
            '{2'd3, 32'h00050000, 32'h00000000},
            '{2'd3, 32'hFFFB0000, 32'h00000000},
            '{2'd3, 32'h80000000, 32'hFFFF0000}
        };
        exp_t        e;
        int          lat;
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 28; i++) begin
            if (i < 12) begin
                o = vecs[i].o; a = vecs[i].a; b = vecs[i].b;
            end else begin
                o = 2'($urandom_range(0, 3));
                a = 32'($signed($urandom) >>> $urandom_range(0, 20));
                b = 32'($signed($urandom) >>> $urandom_range(0, 20));
            end
            sb.push_back(model(o, a, b));
            send_op(o, a, b);
            wait_out(lat);
            if (sb.size() == 0) begin
                checks++; $display("FAIL sb_empty[%0d]: got 0 entries want 1", i);
            end else begin
                e = sb.pop_front();
                checks++; if (lat != e.lat) $display("FAIL latency[%0d] op%0d: got %0d want %0d", i, o, lat, e.lat); else passed++;
                checks++; if (result !== e.res) $display("FAIL result[%0d] op%0d %h,%h: got %h want %h", i, o, a, b, result, e.res); else passed++;
                checks++; if (overflow !== e.ovf) $display("FAIL overflow[%0d]: got %b want %b", i, overflow, e.ovf); else passed++;
                checks++; if (div_zero !== e.dz) $display("FAIL div_zero[%0d]: got %b want %b", i, div_zero, e.dz); else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_div();
        int seen;
        send_op(2'd3, 32'h00030000, 32'h00020000);
        repeat (9) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL middiv_out_valid: got %b want 0", out_valid); else passed++;
        reset_n = 1'b1;
        @(posedge clock); #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL middiv_in_ready: got %b want 1", in_ready); else passed++;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) $display("FAIL middiv_ghost: got %0d valid cycles want 0", seen); else passed++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   lat;
        out_ready = 1'b0;
        sb.push_back(model(2'd2, 32'h00020000, 32'h00018000));
        send_op(2'd2, 32'h00020000, 32'h00018000);
        wait_out(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat) $display("FAIL bp_latency: got %0d want %0d", lat, e.lat); else passed++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); else passed++;
            checks++; if (result !== e.res || overflow !== e.ovf || div_zero !== e.dz)
                $display("FAIL bp_hold[%0d]: got %h/%b/%b want %h/%b/%b", i, result, overflow, div_zero, e.res, e.ovf, e.dz);
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int k = 0; k < 4; k++) begin
            o = 2'(k % 2);
            a = 32'h00010000 * 32'(k + 1);
            b = 32'h00004000 * 32'(k + 3);
            sb.push_back(model(o, a, b));
            in_valid = 1'b1; op = o; valueOne = a; valueTwo = b;
            @(posedge clock); #1;
            e = sb.pop_front();
            checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", k, out_valid); else passed++;
            checks++; if (result !== e.res) $display("FAIL b2b_result[%0d]: got %h want %h", k, result, e.res); else passed++;
            @(posedge clock); #1;
            checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready); else passed++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_reset_mid_div();
        test_backpressure();
        test_back_to_back();
        test_arith();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
